// File: rtl/fios_casc_sched_if.sv
// Handshake and operand-select bundle between the FIOS scheduler and its users.
// master: scheduler side (drives everything except start_i); slave: consumer side.
// Optional macro FIOS_SCHED_CYCCNT_EN adds cyc_cnt_o.
interface fios_casc_sched_if #(
    parameter int WORD_COUNT = 8
);
    localparam int IDXW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

    logic            start_i;
    logic            busy_o;
    logic            done_o;
    logic [IDXW-1:0] i_idx_o;
    logic [IDXW-1:0] j_idx_o;
    logic [1:0]      op_sel_o;
    logic            op_valid_o;
    logic            m_capture_o;
    logic [6:0]      opmode_o;
    logic            creg_en_o;
`ifdef FIOS_SCHED_CYCCNT_EN
    logic [15:0]     cyc_cnt_o;
`endif

    modport master (
        input  start_i,
        output busy_o, done_o, i_idx_o, j_idx_o,
        output op_sel_o, op_valid_o, m_capture_o,
        output opmode_o, creg_en_o
`ifdef FIOS_SCHED_CYCCNT_EN
        , output cyc_cnt_o
`endif
    );

    modport slave (
        output start_i,
        input  busy_o, done_o, i_idx_o, j_idx_o,
        input  op_sel_o, op_valid_o, m_capture_o,
        input  opmode_o, creg_en_o
`ifdef FIOS_SCHED_CYCCNT_EN
        , input cyc_cnt_o
`endif
    );
endinterface

// File: rtl/fios_casc_sched.sv
// Sequencer for a cascaded 17x17 DSP column running a FIOS Montgomery product.
// Ports: clock_i, reset_n_i (async, active low), bus (fios_casc_sched_if.master):
//   start_i in; busy_o/done_o status; i_idx_o/j_idx_o/op_sel_o/op_valid_o operand
//   selects; m_capture_o; opmode_o/creg_en_o skewed to the slice pipeline.
// Optional macro FIOS_SCHED_CYCCNT_EN adds a saturating busy-cycle counter cyc_cnt_o.
module fios_casc_sched #(
    parameter int WORD_COUNT = 8,
    parameter int ABREG      = 1,
    parameter int MREG       = 1,
    parameter int CREG       = 1
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    fios_casc_sched_if.master      bus
);
    localparam int DSP_REG_LEVEL = 1 + ABREG + MREG;
    localparam int IDXW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int DLY  = ABREG + MREG;
    // C register sits CREG stages closer to the adder than A/B -> M
    localparam int CTAP = (DLY > CREG) ? DLY - CREG : 0;

    localparam logic [IDXW-1:0] LAST  = IDXW'(WORD_COUNT - 1);
    localparam logic [1:0]      WLAST = 2'(DSP_REG_LEVEL);

    localparam logic [6:0] OPM_MC   = 7'b0110101;
    localparam logic [6:0] OPM_MP   = 7'b1010101;
    localparam logic [6:0] OPM_M    = 7'b0000101;

    typedef enum logic [2:0] {
        S_IDLE, S_MULT, S_MCALC, S_WAIT_M, S_RED, S_DRAIN, S_DONE
    } state_t;

    typedef struct packed {
        logic [6:0] opmode;
        logic       creg_en;
    } dl_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] i_q, i_d;
    logic [IDXW-1:0] j_q, j_d;
    logic [1:0]      w_q, w_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [1:0]      sel_q, sel_d;
    logic            valid_q, valid_d;
    logic            mcap_q, mcap_d;
    dl_t             dl_q [DLY+1];
    dl_t             dl_d [DLY+1];

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        w_d     = w_q;
        unique case (state_q)
            S_IDLE: if (bus.start_i) begin
                state_d = S_MULT;
                i_d     = '0;
                j_d     = '0;
            end
            S_MULT: if (j_q == LAST) begin
                state_d = S_MCALC;
                j_d     = '0;
            end else begin
                j_d = j_q + 1'b1;
            end
            S_MCALC: begin
                state_d = S_WAIT_M;
                w_d     = '0;
            end
            S_WAIT_M: if (w_q == WLAST) begin
                state_d = S_RED;
                j_d     = '0;
            end else begin
                w_d = w_q + 1'b1;
            end
            S_RED: if (j_q == LAST) begin
                j_d = '0;
                if (i_q == LAST) begin
                    state_d = S_DRAIN;
                    w_d     = '0;
                end else begin
                    state_d = S_MULT;
                    i_d     = i_q + 1'b1;
                end
            end else begin
                j_d = j_q + 1'b1;
            end
            S_DRAIN: if (w_q == WLAST) begin
                state_d = S_DONE;
            end else begin
                w_d = w_q + 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                i_d     = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave a flop
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        mcap_d    = (state_d == S_WAIT_M) && (w_d == WLAST);
        valid_d   = 1'b0;
        sel_d     = 2'b11;
        dl_d[0]   = '0;
        unique case (state_d)
            S_MULT, S_RED: begin
                valid_d           = 1'b1;
                sel_d             = (state_d == S_MULT) ? 2'b00 : 2'b10;
                dl_d[0].opmode    = (j_d == '0) ? OPM_MC : OPM_MP;
                dl_d[0].creg_en   = (j_d == '0);
            end
            S_MCALC: begin
                valid_d        = 1'b1;
                sel_d          = 2'b01;
                dl_d[0].opmode = OPM_M;
            end
            default: ;
        endcase
        for (int k = 1; k <= DLY; k++) begin
            dl_d[k] = dl_q[k-1];
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            w_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= 2'b00;
            valid_q <= 1'b0;
            mcap_q  <= 1'b0;
            for (int k = 0; k <= DLY; k++) begin
                dl_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            w_q     <= w_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            mcap_q  <= mcap_d;
            for (int k = 0; k <= DLY; k++) begin
                dl_q[k] <= dl_d[k];
            end
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.i_idx_o     = i_q;
    assign bus.j_idx_o     = j_q;
    assign bus.op_sel_o    = sel_q;
    assign bus.op_valid_o  = valid_q;
    assign bus.m_capture_o = mcap_q;
    assign bus.opmode_o    = dl_q[DLY].opmode;
    assign bus.creg_en_o   = dl_q[CTAP].creg_en;

`ifdef FIOS_SCHED_CYCCNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counts busy cycles up to DONE, then holds until the next start
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            if (bus.start_i) cnt_d = '0;
        end else if (state_q != S_DONE && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign bus.cyc_cnt_o = cnt_q;
`endif
endmodule
